// File: rtl/note_tone_player.sv
// note_tone_player
//   Tone/duration engine for the music processor's speaker pin and LED segment.
//   Note commands (half-period, duration in ms, LED pattern) arrive over a
//   valid/ready handshake. Each note is played as a square wave for its
//   duration. There is one active note and one pending slot, so back-to-back
//   notes play with no gap between them.
//
// Ports
//   clk              system clock
//   rst_n            synchronous reset, active low
//   ticks_per_milli  clocks per millisecond (0 behaves as 1)
//   cmd_valid        command present
//   cmd_ready        command accepted when cmd_valid & cmd_ready at a clk edge
//   cmd_half_period  clocks between sound toggles; 0 means rest (silent)
//   cmd_duration_ms  note length in milliseconds
//   cmd_led          LED pattern shown while the note plays
//   sound            square-wave speaker drive
//   led              LED segment drive (holds the last pattern when idle)
//   busy             high while a note is active
//   note_done        one-cycle pulse at the end of each note
module note_tone_player #(
    parameter int HP_W  = 16,
    parameter int DUR_W = 10,
    parameter int TPM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TPM_W-1:0] ticks_per_milli,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [HP_W-1:0]  cmd_half_period,
    input  logic [DUR_W-1:0] cmd_duration_ms,
    input  logic [7:0]       cmd_led,
    output logic             sound,
    output logic [7:0]       led,
    output logic             busy,
    output logic             note_done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Control flops (reset)
    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             sound_q, sound_d;
    logic [7:0]       led_q, led_d;
    logic             note_done_q, note_done_d;
    logic             pend_full_q, pend_full_d;
    logic             ready_q, ready_d;

    // Datapath flops (no reset; always loaded before use)
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [HP_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic [TPM_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [HP_W-1:0]  pend_hp_q, pend_hp_d;
    logic [DUR_W-1:0] pend_dur_q, pend_dur_d;
    logic [7:0]       pend_led_q, pend_led_d;

    logic             accept;
    logic [TPM_W-1:0] ms_last;
    logic             ms_term;
    logic             end_now;
    logic             load;
    logic             load_from_pend;

    always_comb begin
        accept  = cmd_valid & ready_q;

        // A zero timebase behaves as one clock per ms. The >= compare lets a
        // lowered ticks_per_milli take effect without the counter running
        // past its new terminal value.
        ms_last = (ticks_per_milli == '0) ? '0 : ticks_per_milli - TPM_W'(1);
        ms_term = (ms_cnt_q >= ms_last);

        // A note ends on its final ms boundary, or immediately on the first
        // PLAY cycle when it was loaded with zero duration.
        end_now = (state_q == PLAY) &&
                  ((rem_q == '0) || (ms_term && (rem_q == DUR_W'(1))));

        state_d        = state_q;
        busy_d         = busy_q;
        sound_d        = sound_q;
        led_d          = led_q;
        note_done_d    = 1'b0;
        pend_full_d    = pend_full_q;
        hp_d           = hp_q;
        tone_cnt_d     = tone_cnt_q;
        ms_cnt_d       = ms_cnt_q;
        rem_d          = rem_q;
        pend_hp_d      = pend_hp_q;
        pend_dur_d     = pend_dur_q;
        pend_led_d     = pend_led_q;
        load           = 1'b0;
        load_from_pend = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end

            PLAY: begin
                if (end_now) begin
                    note_done_d = 1'b1;
                    sound_d     = 1'b0;
                    if (pend_full_q) begin
                        load           = 1'b1;
                        load_from_pend = 1'b1;
                        pend_full_d    = 1'b0;
                    end else if (accept) begin
                        // Pending is empty, so a command arriving on the end
                        // edge bypasses the slot and starts immediately.
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    // Tone generator; a zero half-period is a rest.
                    if (hp_q != '0) begin
                        if (tone_cnt_q == hp_q - HP_W'(1)) begin
                            tone_cnt_d = '0;
                            sound_d    = ~sound_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + HP_W'(1);
                        end
                    end

                    // Millisecond timebase. rem_q is at least 2 here whenever
                    // ms_term is set, so the decrement cannot underflow.
                    if (ms_term) begin
                        ms_cnt_d = '0;
                        rem_d    = rem_q - DUR_W'(1);
                    end else begin
                        ms_cnt_d = ms_cnt_q + TPM_W'(1);
                    end

                    if (accept) begin
                        pend_full_d = 1'b1;
                        pend_hp_d   = cmd_half_period;
                        pend_dur_d  = cmd_duration_ms;
                        pend_led_d  = cmd_led;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sound_d = 1'b0;
            end
        endcase

        // Common note load, from either the pending slot or the command port.
        if (load) begin
            state_d    = PLAY;
            busy_d     = 1'b1;
            sound_d    = 1'b0;
            tone_cnt_d = '0;
            ms_cnt_d   = '0;
            hp_d       = load_from_pend ? pend_hp_q  : cmd_half_period;
            rem_d      = load_from_pend ? pend_dur_q : cmd_duration_ms;
            led_d      = load_from_pend ? pend_led_q : cmd_led;
        end

        // Registered ready: low throughout reset, high the cycle after.
        ready_d = ~pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            sound_q     <= 1'b0;
            led_q       <= '0;
            note_done_q <= 1'b0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            sound_q     <= sound_d;
            led_q       <= led_d;
            note_done_q <= note_done_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        hp_q       <= hp_d;
        tone_cnt_q <= tone_cnt_d;
        ms_cnt_q   <= ms_cnt_d;
        rem_q      <= rem_d;
        pend_hp_q  <= pend_hp_d;
        pend_dur_q <= pend_dur_d;
        pend_led_q <= pend_led_d;
    end

    assign cmd_ready = ready_q;
    assign sound     = sound_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign note_done = note_done_q;

endmodule
